// File: rtl/axi_line_pkg.sv
// axi_line_pkg: shared states, AXI encodings and address alignment for the line master
package axi_line_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Bursts start on a line boundary; single accesses only drop the byte offset.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input logic single,
                                               input int unsigned words);
        logic [31:0] mask;
        mask = single ? 32'd3 : 32'(words * 4) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/axi_line_master.sv
// axi_line_master: AXI3 master for line refills, line writebacks and single-word accesses
module axi_line_master
    import axi_line_pkg::*;
#(
    parameter int          LINE_WORDS = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic                     req_single,
    input  logic [31:0]              req_addr,
    input  logic [3:0]               req_wstrb,
    input  logic [LINE_WORDS*32-1:0] req_wline,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [LINE_WORDS*32-1:0] resp_rline,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int BW = $clog2(LINE_WORDS) + 1;

    state_t                  r_state, w_next;
    logic                    r_we, r_single, r_err;
    logic [3:0]              r_strb;
    logic [31:0]             r_addr;
    logic [BW-1:0]           r_beat;
    logic [LINE_WORDS*32-1:0] r_buf, r_rline;
    logic [7:0]              w_len;
    logic                    w_last, w_accept, w_rbeat, w_wbeat, w_bbeat;
    logic [BW-2:0]           w_widx;
    logic                    w_unused;

    assign w_len    = r_single ? 8'd0 : 8'(LINE_WORDS - 1);
    assign w_last   = 8'(r_beat) == w_len;
    assign w_widx   = r_beat[BW-2:0];
    assign w_accept = req_valid && req_ready;
    assign w_rbeat  = r_state == S_R && rvalid;
    assign w_wbeat  = r_state == S_W && wready;
    assign w_bbeat  = r_state == S_B && bvalid;
    assign w_unused = ^{rid, bid};

    assign req_ready  = r_state == S_IDLE;
    assign resp_valid = r_state == S_DONE;
    assign resp_err   = resp_valid && r_err;
    assign resp_rline = r_rline;

    assign arid    = AXI_ID;
    assign araddr  = r_addr;
    assign arlen   = w_len;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'b000;
    assign arvalid = r_state == S_AR;
    assign rready  = r_state == S_R;

    assign awid    = AXI_ID;
    assign awaddr  = r_addr;
    assign awlen   = w_len;
    assign awsize  = SIZE_4B;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'b000;
    assign awvalid = r_state == S_AW;

    assign wid    = AXI_ID;
    assign wdata  = r_buf[32*w_widx +: 32];
    assign wstrb  = r_single ? r_strb : 4'hF;
    assign wlast  = r_state == S_W && w_last;
    assign wvalid = r_state == S_W;
    assign bready = r_state == S_B;

    // State register; reset aborts any transfer in flight without a completion.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode: each channel phase advances on its own handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = req_valid ? (req_we ? S_AW : S_AR) : S_IDLE;
            S_AR:    w_next = arready ? S_R : S_AR;
            S_R:     w_next = (rvalid && rlast) ? S_DONE : S_R;
            S_AW:    w_next = awready ? S_W : S_AW;
            S_W:     w_next = (wready && w_last) ? S_B : S_W;
            S_B:     w_next = bvalid ? S_DONE : S_B;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, beat counter and sticky error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_we     <= 1'b0;
            r_single <= 1'b0;
            r_strb   <= 4'h0;
            r_addr   <= 32'h0;
            r_buf    <= '0;
            r_err    <= 1'b0;
            r_beat   <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_single <= req_single;
                r_strb   <= req_wstrb;
                r_addr   <= line_align(req_addr, req_single, LINE_WORDS);
                r_buf    <= req_wline;
                r_err    <= 1'b0;
                r_beat   <= '0;
            end
            if (w_rbeat) begin
                if (r_beat < BW'(LINE_WORDS)) r_beat <= r_beat + BW'(1);
                if (rresp != RESP_OKAY || (rlast && !w_last) || r_beat == BW'(LINE_WORDS))
                    r_err <= 1'b1;
            end
            if (w_wbeat) r_beat <= r_beat + BW'(1);
            if (w_bbeat && bresp != RESP_OKAY) r_err <= 1'b1;
        end
    end

    // Read line is filled in place; beats past the end of the line are dropped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rline <= '0;
        else
            for (int i = 0; i < LINE_WORDS; i++)
                if (w_rbeat && r_beat == BW'(i)) r_rline[32*i +: 32] <= rdata;
    end

endmodule
